// File: rtl/cla_mp_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cla_mp_seq (+ cla32)
//  Description : Multi-precision add/subtract sequencer. Operands of NWORD*32
//                bits are captured on an input valid/ready handshake, then
//                streamed one 32-bit word per cycle (LSW first) through an
//                external 32-bit carry-lookahead adder. The carry is chained
//                between words through a register. The full result is held
//                until the output valid/ready handshake completes.
//                cla32 is the 32-bit carry-lookahead adder that sits beside
//                the sequencer.
//  Ports       : i_clk/i_rstn        clock, async active-low reset
//                i_valid/o_ready     operand handshake (accept in IDLE only)
//                i_sub,i_a,i_b,i_c   operation, operands, carry/borrow-in
//                o_valid/i_ready     result handshake
//                o_s,o_c             result, carry-out / borrow-out
//                o_cla_*/i_cla_*     word-serial link to the 32-bit CLA
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_mp_seq #(
    parameter int NWORD = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_sub,
    input  logic [NWORD*32-1:0]   i_a,
    input  logic [NWORD*32-1:0]   i_b,
    input  logic                  i_c,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [NWORD*32-1:0]   o_s,
    output logic                  o_c,
    output logic [31:0]           o_cla_a,
    output logic [31:0]           o_cla_b,
    output logic                  o_cla_c,
    input  logic [31:0]           i_cla_s,
    input  logic                  i_cla_c
);

    localparam int              W        = NWORD * 32;
    localparam int              IDXW     = $clog2(NWORD);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORD - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic [W-1:0]      a_q;
    logic [W-1:0]      bx_q;     // B, already inverted for subtraction
    logic              sub_q;
    logic              cin_q;    // effective carry into word 0 (borrow inverted)
    logic [W-1:0]      s_q;
    logic              c_q;

    logic              w_accept;
    logic              w_last;

    assign w_accept = (state_q == S_IDLE) && i_valid;
    assign w_last   = (idx_q == LAST_IDX);

    // ------------------------------------------------------------------
    // FSM: state register and next-state logic
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_valid)  state_d = S_RUN;
            S_RUN:   if (w_last)   state_d = S_DONE;
            S_DONE:  if (i_ready)  state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            bx_q    <= '0;
            sub_q   <= 1'b0;
            cin_q   <= 1'b0;
            s_q     <= '0;
            c_q     <= 1'b0;
        end else begin
            if (w_accept) begin
                a_q   <= i_a;
                bx_q  <= i_b ^ {W{i_sub}};
                sub_q <= i_sub;
                cin_q <= i_c ^ i_sub;
                idx_q <= '0;
            end
            if (state_q == S_RUN) begin
                s_q[32*idx_q +: 32] <= i_cla_s;
                carry_q             <= i_cla_c;
                if (w_last) begin
                    // Subtraction is a + ~b + ~borrow, so the carry-out is
                    // the complement of the borrow-out.
                    c_q <= i_cla_c ^ sub_q;
                end else begin
                    // idx holds at the last word so it never wraps.
                    idx_q <= idx_q + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_ready = (state_q == S_IDLE);
    assign o_valid = (state_q == S_DONE);
    assign o_s     = s_q;
    assign o_c     = c_q;

    always_comb begin
        o_cla_a = 32'd0;
        o_cla_b = 32'd0;
        o_cla_c = 1'b0;
        if (state_q == S_RUN) begin
            o_cla_a = a_q[32*idx_q +: 32];
            o_cla_b = bx_q[32*idx_q +: 32];
            o_cla_c = (idx_q == '0) ? cin_q : carry_q;
        end
    end

endmodule

// ----------------------------------------------------------------------------
//  cla32: 32-bit adder built from eight 4-bit lookahead groups; group carries
//  are resolved from group generate/propagate terms.
// ----------------------------------------------------------------------------
module cla32 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_c,
    output logic [31:0] o_s,
    output logic        o_c
);

    function automatic logic [32:0] cla_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        cin);
        logic [31:0] g, p, cb;
        logic [8:0]  cg;
        logic        gg, pp;
        g     = a & b;
        p     = a ^ b;
        cb    = '0;
        cg    = '0;
        cg[0] = cin;
        for (int k = 0; k < 8; k++) begin
            cb[4*k]   = cg[k];
            cb[4*k+1] = g[4*k]   | (p[4*k]   & cg[k]);
            cb[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                      | (p[4*k+1] & p[4*k] & cg[k]);
            cb[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                      | (p[4*k+2] & p[4*k+1] & g[4*k])
                      | (p[4*k+2] & p[4*k+1] & p[4*k] & cg[k]);
            gg = g[4*k+3] | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            pp = &p[4*k +: 4];
            cg[k+1] = gg | (pp & cg[k]);
        end
        return {cg[8], p ^ cb};
    endfunction

    assign {o_c, o_s} = cla_add(i_a, i_b, i_c);

endmodule
`default_nettype wire

// File: tb/tb_cla_mp_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla_mp_seq
//  Description : Self-checking bench for cla_mp_seq (NWORD=4) with a cla32
//                instance closing the word-serial loop. Directed cases plus
//                randomized back-to-back operations against an arithmetic
//                reference model of width W+1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_mp_seq;

    localparam int NWORD = 4;
    localparam int W     = NWORD * 32;

    logic          clk;
    logic          rstn;
    logic          i_valid, o_ready, i_sub, i_c, o_valid, i_ready, o_c;
    logic [W-1:0]  i_a, i_b, o_s;
    logic [31:0]   cla_a, cla_b, cla_s;
    logic          cla_ci, cla_co;

    int            n_vec;
    int            n_err;
    logic [W:0]    exp_r;

    cla_mp_seq #(.NWORD(NWORD)) u_dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_sub   (i_sub),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_c     (i_c),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_s     (o_s),
        .o_c     (o_c),
        .o_cla_a (cla_a),
        .o_cla_b (cla_b),
        .o_cla_c (cla_ci),
        .i_cla_s (cla_s),
        .i_cla_c (cla_co)
    );

    cla32 u_cla (
        .i_a (cla_a),
        .i_b (cla_b),
        .i_c (cla_ci),
        .o_s (cla_s),
        .o_c (cla_co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain (W+1)-bit arithmetic. For subtraction a negative
    // difference wraps, setting bit W, which is exactly the borrow-out.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic sub);
        if (sub) return {1'b0, a} - {1'b0, b} - {{W{1'b0}}, c};
        else     return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    function automatic logic [W-1:0] rnd_w();
        logic [W-1:0] v;
        for (int k = 0; k < NWORD; k++) v[32*k +: 32] = $urandom;
        // Bias some words to extremes to exercise long carry chains.
        case ($urandom_range(0, 3))
            0: v[31:0]  = 32'hFFFF_FFFF;
            1: v[63:32] = 32'hFFFF_FFFF;
            default: ;
        endcase
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation and wait for it to be accepted. Inputs are then
    // scrambled to confirm they are only sampled at the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic sub);
        int waited;
        waited = 0;
        while (!o_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!o_ready) chk("ready_timeout", {{W{1'b0}}, o_ready}, {{W{1'b0}}, 1'b1});
        i_a = a; i_b = b; i_c = c; i_sub = sub; i_valid = 1'b1;
        exp_r = model(a, b, c, sub);
        tick();
        i_valid = 1'b0;
        i_a = rnd_w(); i_b = rnd_w(); i_c = 1'($urandom); i_sub = 1'($urandom);
    endtask

    // Called right after the accept edge: checks exact latency, the result,
    // stability during the stall, and that the handshake returns to IDLE.
    task automatic collect(input int stall);
        logic [W:0] held;
        for (int k = 1; k <= NWORD; k++) begin
            tick();
            chk($sformatf("valid_at_%0d", k), {{W{1'b0}}, o_valid},
                {{W{1'b0}}, (k == NWORD)});
        end
        chk("result", {o_c, o_s}, exp_r);
        held = {o_c, o_s};
        for (int k = 0; k < stall; k++) begin
            tick();
            chk("hold_result", {o_c, o_s}, held);
            chk("hold_flags", {{(W-1){1'b0}}, o_valid, o_ready}, {{(W-1){1'b0}}, 2'b10});
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("back_to_idle", {{(W-1){1'b0}}, o_valid, o_ready}, {{(W-1){1'b0}}, 2'b01});
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rstn = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
        i_a = '0; i_b = '0; i_c = 1'b0; i_sub = 1'b0;
        exp_r = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", {{(W-1){1'b0}}, o_valid, o_ready}, {{(W-1){1'b0}}, 2'b01});
        chk("rst_result", {o_c, o_s}, '0);
        chk("rst_cla", {{(W-65){1'b0}}, cla_a, cla_b, cla_ci}, '0);
        rstn = 1'b1;
        tick();

        // 1: full-width carry out
        send({W{1'b1}}, 128'd1, 1'b0, 1'b0);
        chk("t1_model", exp_r, {1'b1, {W{1'b0}}});
        collect(0);

        // 2: subtraction with and without borrow
        send('0, 128'd1, 1'b0, 1'b1);
        chk("t2_model", exp_r, {1'b1, {W{1'b1}}});
        collect(1);
        send(128'd5, 128'd3, 1'b0, 1'b1);
        collect(0);

        // 3: carry rippling across three word boundaries
        send(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0);
        collect(0);

        // 4: backpressure with a pending request held in DONE
        send(128'h1234, 128'h4321, 1'b1, 1'b0);
        i_a = 128'd100; i_b = 128'd58; i_c = 1'b1; i_sub = 1'b1; i_valid = 1'b1;
        collect(5);
        tick();
        chk("t4_pending_accepted", {{W{1'b0}}, o_ready}, '0);
        i_valid = 1'b0;
        exp_r = model(128'd100, 128'd58, 1'b1, 1'b1);
        collect(0);

        // 5: asynchronous reset in the middle of RUN (idx = 2)
        send(rnd_w(), rnd_w(), 1'b1, 1'b0);
        tick();
        tick();
        rstn = 1'b0;
        #1;
        chk("t5_rst_flags", {{(W-1){1'b0}}, o_valid, o_ready}, {{(W-1){1'b0}}, 2'b01});
        chk("t5_rst_result", {o_c, o_s}, '0);
        tick();
        chk("t5_no_valid", {{W{1'b0}}, o_valid}, '0);
        rstn = 1'b1;
        tick();
        send(128'd7, 128'd8, 1'b0, 1'b0);
        chk("t5_model", exp_r, 129'd15);
        collect(0);

        // 6: randomized back-to-back operations with random output stalls
        for (int n = 0; n < 1000; n++) begin
            send(rnd_w(), rnd_w(), 1'($urandom), 1'($urandom));
            collect($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
